// File: rtl/bcd_adder_n_digit_if.sv
// Operand/result bundle for the packed-BCD adder.
// The master drives operands and in_valid; the slave returns the registered sum.
interface bcd_adder_n_digit_if #(
   parameter int N = 3
);
   logic [4*N-1:0] a;
   logic [4*N-1:0] b;
   logic           cin;
   logic           in_valid;
   logic [4*N-1:0] s;
   logic           cout;
   logic           out_valid;
   logic           err;

   modport master (
      output a, b, cin, in_valid,
      input  s, cout, out_valid, err
   );

   modport slave (
      input  a, b, cin, in_valid,
      output s, cout, out_valid, err
   );
endinterface

// File: rtl/bcd_adder_n_digit.sv
// Registered N-digit packed-BCD ripple adder: s = a + b + cin with decimal carry-out.
// One-cycle latency, one operation per cycle, synchronous active-high reset.
module bcd_adder_n_digit #(
   parameter int N = 3
) (
   input logic                  clk,
   input logic                  rst,
   bcd_adder_n_digit_if.slave   bus
);

   logic [4*N-1:0] sum_c;
   logic           cout_c;
   logic           err_c;

   logic [4*N-1:0] s_d, s_q;
   logic           cout_d, cout_q;
   logic           err_d, err_q;
   logic           out_valid_d, out_valid_q;

   // Decimal ripple: each digit adds in 5-bit binary and applies +6 when it overflows 9.
   // Out-of-range nibbles take the same correction path so the result stays deterministic.
   always_comb begin
      logic       carry;
      logic [3:0] da, db;
      logic [4:0] t;
      sum_c = '0;
      err_c = 1'b0;
      carry = bus.cin;
      da    = '0;
      db    = '0;
      t     = '0;
      for (int i = 0; i < N; i++) begin
         da = bus.a[4*i +: 4];
         db = bus.b[4*i +: 4];
         t  = {1'b0, da} + {1'b0, db} + {4'b0, carry};
         if (t > 5'd9) begin
            t                = t + 5'd6;
            sum_c[4*i +: 4]  = t[3:0];
            carry            = 1'b1;
         end else begin
            sum_c[4*i +: 4]  = t[3:0];
            carry            = 1'b0;
         end
         if (da > 4'd9 || db > 4'd9) err_c = 1'b1;
      end
      cout_c = carry;
   end

   // Capture a fresh result when in_valid is high, otherwise hold; out_valid tracks in_valid.
   always_comb begin
      s_d         = s_q;
      cout_d      = cout_q;
      err_d       = err_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         s_d    = sum_c;
         cout_d = cout_c;
         err_d  = err_c;
      end
   end

   // Result registers; reset wins over a simultaneous in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q         <= '0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         cout_q      <= cout_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.err       = err_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_adder_n_digit.sv
// Directed bench for bcd_adder_n_digit: vector table at N=3, hand sequences for
// reset / back-to-back / hold, and an exhaustive single-digit sweep at N=1.
module tb_bcd_adder_n_digit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_adder_n_digit_if #(.N(3)) bus3 ();
   bcd_adder_n_digit_if #(.N(1)) bus1 ();

   bcd_adder_n_digit #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
   bcd_adder_n_digit #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        cin;
      logic [11:0] exp_s;
      logic        exp_cout;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive3(input logic [11:0] a, input logic [11:0] b, input logic cin, input logic v);
      bus3.a        = a;
      bus3.b        = b;
      bus3.cin      = cin;
      bus3.in_valid = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk3(input string name, input logic [11:0] s, input logic c,
                       input logic e, input logic v);
      chk({name, ".s"},         {20'b0, bus3.s},    {20'b0, s});
      chk({name, ".cout"},      {31'b0, bus3.cout}, {31'b0, c});
      chk({name, ".err"},       {31'b0, bus3.err},  {31'b0, e});
      chk({name, ".out_valid"}, {31'b0, bus3.out_valid}, {31'b0, v});
   endtask

   initial begin
      // a, b, cin, expected s, cout, err
      vecs.push_back('{12'h499, 12'h490, 1'b0, 12'h989, 1'b0, 1'b0});
      vecs.push_back('{12'h999, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0});
      vecs.push_back('{12'h999, 12'h999, 1'b1, 12'h999, 1'b1, 1'b0});
      vecs.push_back('{12'h111, 12'h21C, 1'b0, 12'h333, 1'b0, 1'b1});
      vecs.push_back('{12'h075, 12'h040, 1'b0, 12'h115, 1'b0, 1'b0});
      vecs.push_back('{12'h000, 12'h000, 1'b1, 12'h001, 1'b0, 1'b0});
      vecs.push_back('{12'h500, 12'h500, 1'b0, 12'h000, 1'b1, 1'b0});
      vecs.push_back('{12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0});
      vecs.push_back('{12'h0FF, 12'h000, 1'b0, 12'h165, 1'b0, 1'b1});
      vecs.push_back('{12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0});

      bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;

      // Reset held two cycles with in_valid high and nonzero operands.
      rst = 1'b1;
      drive3(12'h999, 12'h999, 1'b1, 1'b1);
      step();
      chk3("reset1", 12'h000, 1'b0, 1'b0, 1'b0);
      step();
      chk3("reset2", 12'h000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      drive3(12'h000, 12'h000, 1'b0, 1'b0);
      step();

      // Table vectors, each issued alone and checked one cycle later.
      foreach (vecs[i]) begin
         drive3(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
         step();
         chk3($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_err, 1'b1);
         drive3(12'h000, 12'h000, 1'b0, 1'b0);
         step();
      end

      // Back-to-back issue, then drop in_valid and verify hold.
      drive3(12'h499, 12'h490, 1'b0, 1'b1);
      step();
      chk3("b2b0", 12'h989, 1'b0, 1'b0, 1'b1);
      drive3(12'h111, 12'h21C, 1'b0, 1'b1);
      step();
      chk3("b2b1", 12'h333, 1'b0, 1'b1, 1'b1);
      drive3(12'h999, 12'h999, 1'b1, 1'b1);
      step();
      chk3("b2b2", 12'h999, 1'b1, 1'b0, 1'b1);
      drive3(12'h075, 12'h040, 1'b0, 1'b0);
      step();
      chk3("hold0", 12'h999, 1'b1, 1'b0, 1'b0);
      step();
      chk3("hold1", 12'h999, 1'b1, 1'b0, 1'b0);

      // Reset mid-stream beats in_valid.
      drive3(12'h111, 12'h21C, 1'b0, 1'b1);
      step();
      chk3("prerst", 12'h333, 1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      drive3(12'h999, 12'h001, 1'b0, 1'b1);
      step();
      chk3("midrst", 12'h000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk3("postrst", 12'h000, 1'b1, 1'b0, 1'b1);
      drive3(12'h000, 12'h000, 1'b0, 1'b0);

      // Exhaustive single-digit sweep.
      for (int x = 0; x < 10; x++) begin
         for (int y = 0; y < 10; y++) begin
            for (int c = 0; c < 2; c++) begin
               int sum;
               sum = x + y + c;
               bus1.a = 4'(x); bus1.b = 4'(y); bus1.cin = 1'(c); bus1.in_valid = 1'b1;
               step();
               chk($sformatf("n1_%0d_%0d_%0d.s", x, y, c), {28'b0, bus1.s}, 32'(sum % 10));
               chk($sformatf("n1_%0d_%0d_%0d.cout", x, y, c), {31'b0, bus1.cout}, 32'(sum / 10));
               if (bus1.err !== 1'b0 || bus1.out_valid !== 1'b1) begin
                  checks++;
                  failures++;
                  $display("FAIL n1_%0d_%0d_%0d.flags: err=%b out_valid=%b expected err=0 out_valid=1",
                           x, y, c, bus1.err, bus1.out_valid);
               end else begin
                  checks++;
               end
            end
         end
      end
      bus1.in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
